uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_SRC packet sources, such as order-entry and telemetry streams.
- Picks one source with round-robin arbitration and locks the grant for that source's whole packet, so bytes from different sources never interleave on the line.
- Paces bytes into the transmitter using its en/busy handshake.
- Sits between the message formatters and the UART transmitter instance.

Parameters:
- NUM_SRC, 4: number of requesting sources (2..8).
- PAYLOAD_BITS, 8: byte width; must match the transmitter.
- TIMEOUT_CYCLES, 1_000_000: cycles a granted source may stall mid-packet before abort. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NUM_SRC  per-source byte available.
- src_data  in  NUM_SRC*PAYLOAD_BITS  per-source byte; source i uses bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- src_last  in  NUM_SRC  per-source: the current byte ends the packet.
- src_ready  out  NUM_SRC  one-cycle pulse: byte accepted from that source.
- grant  out  NUM_SRC  one-hot current owner; all zero when idle.
- uart_tx_en  out  1  to transmitter: start a byte.
- uart_tx_data  out  PAYLOAD_BITS  to transmitter: the byte.
- uart_tx_busy  in  1  from transmitter: a byte is in flight.
- pkt_done  out  1  one-cycle pulse: last byte of the packet fully transmitted.
- pkt_abort  out  1  one-cycle pulse: packet aborted by timeout.

Behaviour:
- Reset values:
  - state = IDLE.
  - grant, src_ready, uart_tx_en, pkt_done, pkt_abort = 0.
  - uart_tx_data = 0.
  - rr_ptr = 0, so source 0 has highest priority.
  - Stall counter = 0.
- Reset is honoured in any state, including mid-packet. A byte already inside the transmitter finishes on its own. After reset the controller only issues a new byte once it sees uart_tx_busy=0 in SEND.
- Registered outputs: grant, uart_tx_en, uart_tx_data, pkt_done, pkt_abort.
- Combinational output: src_ready = (state==SEND) & grant & src_valid & ~uart_tx_busy.
- IDLE:
  - If any src_valid is high, grant the first valid index found searching cyclically from rr_ptr upward.
  - Next cycle: grant is one-hot and state = SEND.
  - src_last is not examined here.
- SEND (g = granted index):
  - If src_valid[g]=1 and uart_tx_busy=0:
    - src_ready[g] pulses this cycle.
    - uart_tx_data <= src_data[g]; last_q <= src_last[g]; uart_tx_en <= 1.
    - Stall counter clears; next state WAIT_HI.
  - Otherwise the stall counter increments while src_valid[g]=0.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 with valid still low:
    - pkt_abort pulses; grant clears; rr_ptr <= g+1 (mod NUM_SRC); next state IDLE.
- WAIT_HI:
  - uart_tx_en is high for exactly one cycle (the first WAIT_HI cycle), then deasserts.
  - Stay until uart_tx_busy=1, then go to WAIT_LO. Busy is normally seen one cycle after en.
- WAIT_LO:
  - Stay until uart_tx_busy=0.
  - If last_q=0: go to SEND, grant held.
  - If last_q=1: pkt_done pulses next cycle; grant clears; rr_ptr <= g+1 (mod NUM_SRC); go to IDLE.
- Packet boundaries and fairness:
  - A single-byte packet has src_last high on its first byte.
  - A source that re-asserts valid immediately after pkt_done waits behind all other requesting sources.
  - While a grant is held, src_valid/src_last of non-granted sources are ignored, and their src_ready stays 0.
- Throughput: at most one byte per transmitter frame. The controller adds 3 cycles per byte: SEND, the en cycle, and the busy-fall detect.
- The stall counter is sized $clog2(TIMEOUT_CYCLES+1) bits and saturates. It never wraps.

Test Plan:
1. Single source: NUM_SRC=4, source 2 sends packet {0xA5, 0x3C(last)}, transmitter busy held 10 cycles per byte -> grant=0100 throughout; uart_tx_en pulses exactly twice with data 0xA5 then 0x3C; pkt_done one cycle after busy falls on 0x3C; grant=0000.
2. Contention: sources 0, 1, 3 all request 2-byte packets at once after reset -> service order 0, 1, 3; each grant held for both bytes; no interleaving.
3. Fairness: source 0 re-requests immediately after its pkt_done while source 3 is waiting -> source 3 granted before source 0.
4. Stall timeout: TIMEOUT_CYCLES=16, source 1 sends byte 0x11 (not last) then drops valid -> pkt_abort at the 16th stalled cycle; grant clears; next valid source (2) is granted afterwards.
5. Busy hold-off: uart_tx_busy forced high while a source is granted with valid data -> no src_ready and no uart_tx_en until busy falls, then exactly one en.
6. Reset mid-packet: reset asserted during WAIT_LO of byte 1 of a 3-byte packet -> next cycle all outputs are 0; rr_ptr=0; the controller later issues no uart_tx_en while uart_tx_busy=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between several packet sources.
// A grant is held for a whole packet, so bytes from different sources never interleave.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned PAYLOAD_BITS   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC*PAYLOAD_BITS-1:0] src_data,
  input  logic [NUM_SRC-1:0]              src_last,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic [NUM_SRC-1:0]              grant,
  output logic                            uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
  input  logic                            uart_tx_busy,
  output logic                            pkt_done,
  output logic                            pkt_abort
);

  localparam int unsigned IdxW   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned StallW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [StallW-1:0] StallMax   = '1;
  localparam logic [StallW-1:0] StallLimit =
      StallW'((TIMEOUT_CYCLES == 0) ? 0 : (TIMEOUT_CYCLES - 1));

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWaitHi,
    StWaitLo
  } state_e;

  state_e                    state_q, state_d;
  logic [NUM_SRC-1:0]        grant_q, grant_d;
  logic [IdxW-1:0]           gidx_q, gidx_d;
  logic [IdxW-1:0]           rr_ptr_q, rr_ptr_d;
  logic                      en_q, en_d;
  logic [PAYLOAD_BITS-1:0]   data_q, data_d;
  logic                      last_q, last_d;
  logic                      done_q, done_d;
  logic                      abort_q, abort_d;
  logic [StallW-1:0]         stall_q, stall_d;

  logic                      pick_found;
  logic [IdxW-1:0]           pick_idx;
  logic                      sel_valid;
  logic                      sel_last;
  logic [PAYLOAD_BITS-1:0]   sel_data;

  function automatic logic [IdxW-1:0] inc_idx(input logic [IdxW-1:0] i);
    return (i == IdxW'(NUM_SRC - 1)) ? '0 : i + IdxW'(1);
  endfunction

  // First requesting source found searching cyclically upward from rr_ptr.
  always_comb begin
    logic [IdxW:0] cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
      if (cand >= (IdxW+1)'(NUM_SRC)) begin
        cand = cand - (IdxW+1)'(NUM_SRC);
      end
      if (!pick_found && src_valid[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Granted source's request, selected through the one-hot grant.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        sel_valid = src_valid[i];
        sel_last  = src_last[i];
        sel_data  = src_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    en_d     = 1'b0;
    data_d   = data_q;
    last_d   = last_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;
    stall_d  = stall_q;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = NUM_SRC'(1) << pick_idx;
          gidx_d  = pick_idx;
          stall_d = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (sel_valid && !uart_tx_busy) begin
          data_d  = sel_data;
          last_d  = sel_last;
          en_d    = 1'b1;
          stall_d = '0;
          state_d = StWaitHi;
        end else if (!sel_valid) begin
          if ((TIMEOUT_CYCLES != 0) && (stall_q >= StallLimit)) begin
            abort_d  = 1'b1;
            grant_d  = '0;
            rr_ptr_d = inc_idx(gidx_q);
            stall_d  = '0;
            state_d  = StIdle;
          end else if (stall_q != StallMax) begin
            stall_d = stall_q + StallW'(1);
          end
        end
      end
      StWaitHi: begin
        if (uart_tx_busy) begin
          state_d = StWaitLo;
        end
      end
      StWaitLo: begin
        if (!uart_tx_busy) begin
          if (last_q) begin
            done_d   = 1'b1;
            grant_d  = '0;
            rr_ptr_d = inc_idx(gidx_q);
            state_d  = StIdle;
          end else begin
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      rr_ptr_q <= '0;
      en_q     <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      en_q     <= en_d;
      data_q   <= data_d;
      last_q   <= last_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      stall_q  <= stall_d;
    end
  end

  assign src_ready    = (state_q == StSend) ?
                        (grant_q & src_valid & {NUM_SRC{~uart_tx_busy}}) : '0;
  assign grant        = grant_q;
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;
  assign pkt_done     = done_q;
  assign pkt_abort    = abort_q;

endmodule
